zl_prbs_engine: RTL and testbench

Parametrised multi-mode PRBS engine: generation, additive scrambling/descrambling and PRBS checking from one LFSR core. It has a valid/ready stream interface in and out. The block sits in the DVB transmit/receive datapath between byte framing and the modulator/demodulator, and is the general successor to the free-running LFSR. Checker mode adds self-synchronising lock acquisition, loss-of-lock detection and bit-error counting.

---
 rtl/zl_prbs_engine.sv | 169 ++++++++++++++++
 tb/tb_zl_prbs_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/zl_prbs_engine.sv
// Multi-mode PRBS engine (generate / additive scramble / check) around one LFSR core.
// Define ZL_PRBS_ERR_CNT_EN to build the saturating 32-bit bit-error counter.
module zl_prbs_engine #(
  parameter int                      LFSR_width      = 7,
  parameter logic [LFSR_width:0]     LFSR_poly       = 8'hC1,
  parameter logic [LFSR_width-1:0]   LFSR_init_value = 7'h7F,
  parameter int                      DATA_width      = 8,
  parameter int                      LOCK_CNT        = 4,
  parameter int                      LOSS_CNT        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_width-1:0] out_data,
  output logic [LFSR_width-1:0] lfsr_state,
  output logic                  locked,
  output logic [31:0]           err_cnt
);

  typedef enum logic {HUNT, LOCKED} fsm_t;

  localparam logic [LFSR_width-1:0] TAPS    = LFSR_poly[LFSR_width:1];
  localparam logic [7:0]            LOCK_TH = 8'(LOCK_CNT);
  localparam logic [7:0]            LOSS_TH = 8'(LOSS_CNT);

  logic [LFSR_width-1:0] lfsr_q, lfsr_adv, lfsr_d;
  logic [DATA_width-1:0] prbs, err_map, word_d;
  logic [DATA_width-1:0] data_p1;
  logic                  vld_p1;
  logic                  fb;
  fsm_t                  fsm_q, fsm_d;
  logic [7:0]            match_q, match_d, miss_q, miss_d;
  logic                  accept, is_check, word_err, reseed;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_check = (mode == 2'b10);

  // Stage p0: DATA_width serial LFSR steps unrolled into one word, MSb first
  always_comb begin
    lfsr_adv = lfsr_q;
    prbs     = '0;
    fb       = 1'b0;
    for (int i = 0; i < DATA_width; i++) begin
      fb                   = ^(lfsr_adv & TAPS);
      prbs[DATA_width-1-i] = fb;
      lfsr_adv             = {lfsr_adv[LFSR_width-2:0], fb};
    end
  end

  assign err_map  = in_data ^ prbs;
  assign word_err = |err_map;
  assign word_d   = (mode == 2'b00) ? prbs : err_map;
  assign lfsr_d   = reseed ? in_data[LFSR_width-1:0] : lfsr_adv;

  always_comb begin
    fsm_d   = fsm_q;
    match_d = match_q;
    miss_d  = miss_q;
    reseed  = 1'b0;
    if (!is_check) begin
      fsm_d   = HUNT;
      match_d = '0;
      miss_d  = '0;
    end else if (accept) begin
      case (fsm_q)
        HUNT: begin
          if (word_err) begin
            // Self-synchronise: the last LFSR_width received bits are the next state
            match_d = '0;
            reseed  = 1'b1;
          end else if (match_q + 8'd1 == LOCK_TH) begin
            fsm_d   = LOCKED;
            match_d = '0;
            miss_d  = '0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        default: begin
          if (!word_err) begin
            miss_d = '0;
          end else if (miss_q + 8'd1 == LOSS_TH) begin
            fsm_d   = HUNT;
            match_d = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + 8'd1;
          end
        end
      endcase
    end
    if (clear) begin
      fsm_d   = HUNT;
      match_d = '0;
      miss_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= HUNT;
      match_q <= '0;
      miss_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  // Stage p1: registered output word, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= LFSR_init_value;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (clear)       lfsr_q <= LFSR_init_value;
      else if (accept) lfsr_q <= lfsr_d;
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= word_d;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign lfsr_state = lfsr_q;
  assign locked     = (fsm_q == LOCKED);

`ifdef ZL_PRBS_ERR_CNT_EN
  logic [31:0] err_q;

  function automatic logic [31:0] popcount(input logic [DATA_width-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < DATA_width; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear)
      err_q <= '0;
    else if (accept && is_check && fsm_q == LOCKED)
      err_q <= sat_add(err_q, popcount(err_map));
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_zl_prbs_engine.sv
// Directed bench for zl_prbs_engine (PRBS7): GEN, scramble/descramble, CHECK lock/loss, backpressure, clear.
module tb_zl_prbs_engine;

`ifdef ZL_PRBS_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [1:0]  mode;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, locked;
  logic [7:0]  out_data;
  logic [6:0]  lfsr_state;
  logic [31:0] err_cnt;

  logic        d_in_ready, d_out_valid, d_locked;
  logic [7:0]  d_out_data;
  logic [6:0]  d_lfsr;
  logic [31:0] d_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zl_prbs_engine #(.LFSR_width(7), .LFSR_poly(8'hC1), .LFSR_init_value(7'h7F),
                   .DATA_width(8), .LOCK_CNT(4), .LOSS_CNT(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lfsr_state(lfsr_state), .locked(locked), .err_cnt(err_cnt));

  zl_prbs_engine #(.LFSR_width(7), .LFSR_poly(8'hC1), .LFSR_init_value(7'h7F),
                   .DATA_width(8), .LOCK_CNT(4), .LOSS_CNT(4)) u_dsc (
    .clk(clk), .rst(rst), .mode(2'b01), .clear(1'b0),
    .in_valid(out_valid), .in_ready(d_in_ready), .in_data(out_data),
    .out_valid(d_out_valid), .out_ready(1'b1), .out_data(d_out_data),
    .lfsr_state(d_lfsr), .locked(d_locked), .err_cnt(d_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference PRBS7 (x^7 + x^6 + 1): one word of 8 bits, MSb first
  function automatic void adv(inout logic [6:0] st, output logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      w[7-i] = st[6] ^ st[5];
      st     = {st[5:0], w[7-i]};
    end
  endfunction

  function automatic logic [31:0] exp_err(input int v);
    return ERR_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] ms;
    logic [7:0] w, held;
    logic [7:0] q[$];
    logic       hold_pend;
    int         got, cons, offset;

    mode = 2'b00; in_data = 8'h00;
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_lfsr", lfsr_state, 7'h7F);
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // GEN: hand-computed first three PRBS7 words from 7F
    in_valid = 1'b1; in_data = 8'hAA;
    tick();
    chk("gen_w0_valid", out_valid, 1);
    chk("gen_w0", out_data, 8'h02);
    chk("gen_w0_state", lfsr_state, 7'h02);
    in_data = 8'h55;
    tick();
    chk("gen_w1", out_data, 8'h0C);
    chk("gen_w1_state", lfsr_state, 7'h0C);
    tick();
    chk("gen_w2", out_data, 8'h28);
    in_valid = 1'b0;
    tick();
    chk("gen_idle_valid", out_valid, 0);
    chk("gen_idle_state", lfsr_state, 7'h28);

    // SCRAMBLE -> second instance descrambles
    do_reset();
    mode = 2'b01;
    got = 0;
    for (int k = 0; k < 1004; k++) begin
      if (k < 1001) begin
        in_valid = 1'b1;
        in_data  = (k == 0) ? 8'hFF : 8'($urandom);
        q.push_back(in_data);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k == 0) chk("scr_first", out_data, 8'hFD);
      if (d_out_valid) begin
        if (q.size() > 0) chk("descr_word", d_out_data, q.pop_front());
        got++;
      end
    end
    chk("descr_count", got, 1001);
    ms = 7'h7F;
    for (int k = 0; k < 1001; k++) adv(ms, w);
    chk("scr_state", lfsr_state, ms);
    chk("dsc_state", d_lfsr, ms);
    chk("dsc_ready", d_in_ready, 1);
    chk("dsc_locked", d_locked, 0);
    chk("dsc_err", d_err, 0);

    // CHECK: lock onto the GEN stream from a random offset
    do_reset();
    mode = 2'b10;
    ms = 7'h7F;
    offset = $urandom_range(1, 100);
    for (int k = 0; k < offset; k++) adv(ms, w);
    for (int k = 0; k < 5; k++) begin
      adv(ms, w);
      in_valid = 1'b1; in_data = w;
      tick();
      if (k == 3) chk("chk_not_yet", locked, 0);
    end
    chk("chk_locked", locked, 1);
    chk("chk_lock_err", err_cnt, 0);
    chk("chk_lock_map", out_data, 8'h00);
    chk("chk_lock_state", lfsr_state, ms);

    adv(ms, w); in_data = w ^ 8'h10;
    tick();
    chk("single_map", out_data, 8'h10);
    chk("single_err", err_cnt, exp_err(1));
    chk("single_locked", locked, 1);
    adv(ms, w); in_data = w;
    tick();
    chk("clean_map", out_data, 8'h00);
    chk("clean_locked", locked, 1);
    for (int k = 0; k < 4; k++) begin
      adv(ms, w); in_data = ~w;
      tick();
      chk("inv_map", out_data, 8'hFF);
      if (k < 3) chk("inv_still_locked", locked, 1);
    end
    chk("loss_locked", locked, 0);
    chk("loss_err", err_cnt, exp_err(33));
    in_valid = 1'b0;

    // Backpressure: in_valid held high, out_ready random
    do_reset();
    mode = 2'b00;
    ms = 7'h7F;
    cons = 0; hold_pend = 1'b0; held = 8'h00;
    in_valid = 1'b1; in_data = 8'h5A;
    for (int c = 0; c < 300; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold_pend) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      chk("bp_in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        adv(ms, w);
        chk("bp_data", out_data, w);
        cons++;
      end
      hold_pend = out_valid && !out_ready;
      held      = out_data;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid) begin
      adv(ms, w);
      chk("bp_drain", out_data, w);
      cons++;
    end
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_state", lfsr_state, ms);

    // clear together with an accept while locked with errors counted
    mode = 2'b10;
    for (int k = 0; k < 4; k++) begin
      adv(ms, w);
      in_valid = 1'b1; in_data = w;
      tick();
    end
    chk("relock", locked, 1);
    adv(ms, w); in_data = ~w;
    tick();
    chk("pre_clear_err", err_cnt, exp_err(8));
    chk("pre_clear_locked", locked, 1);
    adv(ms, w); in_data = w; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_out_valid", out_valid, 1);
    chk("clear_out_data", out_data, 8'h00);
    chk("clear_state", lfsr_state, 7'h7F);
    chk("clear_locked", locked, 0);
    chk("clear_err", err_cnt, 0);
    mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_clear_gen", out_data, 8'h02);
    chk("post_clear_state", lfsr_state, 7'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
